// File: rtl/serial_add_scheduler_if.sv
// Handshake bundle for the shared serial adder: two job request ports,
// the bit-serial full-adder lane, and the result response port.
interface serial_add_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             fa_a;
  logic             fa_b;
  logic             fa_cin;
  logic             fa_sum;
  logic             fa_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;

  // Scheduler side
  modport master (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output fa_a, fa_b, fa_cin,
    input  fa_sum, fa_cout,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout,
    input  rsp_ready
  );

  // Requesters, adder and result consumer
  modport slave (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  fa_a, fa_b, fa_cin,
    output fa_sum, fa_cout,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
    output rsp_ready
  );
endinterface

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler that time-shares one external 1-bit full adder between
// two requesters, running each WIDTH-bit add LSB first and returning sum/carry.
module serial_add_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  serial_add_scheduler_if.master         bus
);

  localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             id_reg;
  logic             last_id;
  logic             grant0;
  logic             grant1;
  logic             in_add;
  logic             in_resp;

  // last_id==1 means requester 1 was served last, so requester 0 wins a tie
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && (state == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_id;
        grant1 = ~last_id;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign in_add  = (state == ADD);
  assign in_resp = (state == RESP);

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign bus.fa_a   = in_add & a_reg[idx];
  assign bus.fa_b   = in_add & b_reg[idx];
  assign bus.fa_cin = in_add & carry_reg;

  assign bus.rsp_valid = in_resp;
  assign bus.rsp_id    = in_resp & id_reg;
  assign bus.rsp_sum   = in_resp ? sum_reg : '0;
  assign bus.rsp_cout  = in_resp & carry_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      id_reg    <= 1'b0;
      last_id   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_reg     <= grant1 ? bus.req1_a   : bus.req0_a;
            b_reg     <= grant1 ? bus.req1_b   : bus.req0_b;
            carry_reg <= grant1 ? bus.req1_cin : bus.req0_cin;
            id_reg    <= grant1;
            idx       <= '0;
            state     <= ADD;
          end
        end
        ADD: begin
          // The adder is combinational, so its outputs for bit idx are valid now
          sum_reg[idx] <= bus.fa_sum;
          carry_reg    <= bus.fa_cout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= RESP;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            last_id <= id_reg;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Randomized and directed bench for serial_add_scheduler against a
// transaction-level model driven by an ideal full adder on the fa_* lane.
module tb_serial_add_scheduler;
  localparam int WIDTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  serial_add_scheduler_if #(.WIDTH(WIDTH)) bus ();

  serial_add_scheduler #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.fa_sum  = bus.fa_a ^ bus.fa_b ^ bus.fa_cin;
  assign bus.fa_cout = (bus.fa_a & bus.fa_b) | (bus.fa_cin & (bus.fa_a ^ bus.fa_b));

  int checks = 0;
  int errors = 0;

  // Reference model: one job in flight, k = cycles since accept
  bit               busy = 0;
  int               k = 0;
  int               ja, jb, jcin;
  bit               jid;
  bit               last = 1;
  bit               post_rst = 0;
  bit               acc0, acc1, seen_rsp;
  int               grant_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input bit n);
    if (n) begin
      bus.req1_valid = 1'b1;
      bus.req1_a     = WIDTH'($urandom);
      bus.req1_b     = WIDTH'($urandom);
      bus.req1_cin   = 1'($urandom);
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_a     = WIDTH'($urandom);
      bus.req0_b     = WIDTH'($urandom);
      bus.req0_cin   = 1'($urandom);
    end
  endtask

  // Called right after a negedge with inputs set; checks, advances model, returns at next negedge
  task automatic step();
    bit e_r0, e_r1;
    int m, carry, full;
    #1;
    e_r0 = 0;
    e_r1 = 0;
    if (reset && !busy) begin
      e_r0 = bus.req0_valid && (!bus.req1_valid || last);
      e_r1 = bus.req1_valid && (!bus.req0_valid || !last);
    end
    chk("req0_ready", bus.req0_ready, e_r0);
    chk("req1_ready", bus.req1_ready, e_r1);
    if (reset) begin
      if (busy && k <= WIDTH) begin
        m     = (1 << (k - 1)) - 1;
        carry = (((ja & m) + (jb & m) + jcin) >> (k - 1)) & 1;
        chk("fa_a", bus.fa_a, (ja >> (k - 1)) & 1);
        chk("fa_b", bus.fa_b, (jb >> (k - 1)) & 1);
        chk("fa_cin", bus.fa_cin, carry);
      end else begin
        chk("fa_idle", {bus.fa_a, bus.fa_b, bus.fa_cin}, 0);
      end
      chk("rsp_valid", bus.rsp_valid, busy && k == WIDTH + 1);
      if (busy && k == WIDTH + 1) begin
        full = ja + jb + jcin;
        chk("rsp_sum", bus.rsp_sum, full & ((1 << WIDTH) - 1));
        chk("rsp_cout", bus.rsp_cout, (full >> WIDTH) & 1);
        chk("rsp_id", bus.rsp_id, jid);
      end else if (post_rst) begin
        chk("rst_rsp", {bus.rsp_id, bus.rsp_cout, bus.rsp_sum}, 0);
      end
    end
    seen_rsp = bus.rsp_valid;
    acc0 = bus.req0_valid && bus.req0_ready;
    acc1 = bus.req1_valid && bus.req1_ready;
    if (acc1) grant_q.push_back(1);
    else if (acc0) grant_q.push_back(0);
    post_rst = 0;
    if (!reset) begin
      busy = 0; k = 0; last = 1; post_rst = 1;
    end else if (!busy) begin
      if (e_r0 || e_r1) begin
        busy = 1;
        k    = 1;
        jid  = e_r1;
        ja   = e_r1 ? int'(bus.req1_a)   : int'(bus.req0_a);
        jb   = e_r1 ? int'(bus.req1_b)   : int'(bus.req0_b);
        jcin = e_r1 ? int'(bus.req1_cin) : int'(bus.req0_cin);
      end
    end else if (k <= WIDTH) begin
      k++;
    end else if (bus.rsp_ready) begin
      busy = 0;
      last = jid;
    end
    @(negedge clock);
  endtask

  // Offer a job (on one or both ports), check who wins, latency and hold behaviour
  task automatic run_job(input bit v0, input bit v1, input bit exp_id,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input int hold, input string tag);
    int  n;
    bit  got;
    bus.req0_valid = v0;  bus.req0_a = a;  bus.req0_b = b;  bus.req0_cin = cin;
    bus.req1_valid = v1;  bus.req1_a = a;  bus.req1_b = b;  bus.req1_cin = cin;
    if (v0 && v1) begin
      if (exp_id) begin bus.req0_a = ~a; bus.req0_b = ~b; end
      else        begin bus.req1_a = ~a; bus.req1_b = ~b; end
    end
    bus.rsp_ready = (hold == 0);
    got = 0;
    for (n = 0; n < 50 && !got; n++) begin
      step();
      got = acc0 || acc1;
    end
    chk({tag, "_accept"}, got, 1);
    chk({tag, "_winner"}, acc1, exp_id);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n = 0;
    got = 0;
    while (n < 50 && !got) begin
      if (hold > 0 && n == WIDTH) begin
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
      end
      step();
      n++;
      got = seen_rsp;
    end
    chk({tag, "_latency"}, n, WIDTH + 1);
    if (hold > 0) begin
      repeat (hold - 1) step();
      bus.rsp_ready = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      step();
      chk({tag, "_no_stale_grant"}, busy, 0);
    end
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 0;
    bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 0;
    bus.rsp_ready  = 0;
    @(negedge clock);
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    repeat (2) step();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    reset = 1'b1;
    step();

    // Directed arithmetic
    run_job(1, 0, 0, 8'hA5, 8'h3C, 1'b0, 0, "t1");
    run_job(1, 0, 0, 8'hFF, 8'h01, 1'b0, 0, "t2a");
    run_job(0, 1, 1, 8'hFF, 8'hFF, 1'b1, 0, "t2b");

    // Both requesters continuously valid: grants must alternate starting with req0
    grant_q.delete();
    bus.rsp_ready = 1'b1;
    set_req(0);
    set_req(1);
    for (int n = 0; n < 100 && grant_q.size() < 4; n++) begin
      step();
      if (acc0) set_req(0);
      if (acc1) set_req(1);
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    chk("alt_count", grant_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_q.size()) chk("alt_id", grant_q[i], i % 2);
    for (int n = 0; n < 30 && busy; n++) step();

    // Consumer stalls for 5 cycles while both requesters are waiting
    run_job(1, 0, 0, 8'h5A, 8'hC3, 1'b1, 5, "t4");

    // Abort a req1 job at bit 3 after req0 was last served; reset restores req0 priority
    run_job(1, 0, 0, 8'h12, 8'h34, 1'b0, 0, "t5pre");
    bus.rsp_ready = 1'b1;
    set_req(1);
    begin
      bit got;
      got = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        step();
        got = acc1;
      end
      chk("t5_accept", got, 1);
    end
    bus.req1_valid = 0;
    repeat (3) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int n = 0; n < 14; n++) begin
      step();
      chk("t5_no_rsp", seen_rsp, 0);
    end
    run_job(1, 1, 0, 8'h77, 8'h99, 1'b1, 0, "t5post");

    // Random traffic with random backpressure and rare resets
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    for (int n = 0; n < 600; n++) begin
      if (acc0) bus.req0_valid = 0;
      if (acc1) bus.req1_valid = 0;
      if (!bus.req0_valid && ($urandom % 3 == 0)) set_req(0);
      if (!bus.req1_valid && ($urandom % 3 == 0)) set_req(1);
      bus.rsp_ready = ($urandom % 4) != 0;
      reset = ($urandom % 150) != 0;
      step();
    end
    reset = 1'b1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.rsp_ready = 1;
    for (int n = 0; n < 30 && busy; n++) step();
    chk("drain_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
